// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline constants: opcode encodings and register-index width, used by
// the hazard unit and the forwarding logic.
package hazard_stall_unit_pkg;

  localparam int REG_INDEX_BIT_WIDTH = 4;

  localparam logic [3:0] OP_NOP    = 4'b0000;
  localparam logic [3:0] OP_BRANCH = 4'b0010;
  localparam logic [3:0] OP_SW     = 4'b0011;
  localparam logic [3:0] OP_LW     = 4'b0100;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/hazard_stall_unit_load_scoreboard.sv
// Outstanding-load scoreboard: one bit per register, set on load issue and
// cleared on load writeback. A set and a clear of the same bit in one cycle leaves it set.
module load_scoreboard #(
  parameter int NUM_REGS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REGS-1:0] set_vec,
  input  logic [NUM_REGS-1:0] clear_vec,
  output logic [NUM_REGS-1:0] pending_mask
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_mask <= '0;
    end else begin
      // OR-ing the set after the clear is what makes set win on a collision.
      pending_mask <= (pending_mask & ~clear_vec) | set_vec;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use hazard detection and memory-wait freeze control for a 5-stage
// pipeline, with a saturating stall counter and a sticky memory timeout flag.
module hazard_stall_unit #(
  parameter int REG_INDEX_BIT_WIDTH = hazard_stall_unit_pkg::REG_INDEX_BIT_WIDTH,
  parameter int STALL_CNT_WIDTH     = 16,
  parameter int MAX_WAIT            = 255
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                ID_valid,
  input  logic [3:0]                          ID_opcode,
  input  logic [REG_INDEX_BIT_WIDTH-1:0]      ID_src1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0]      ID_src2,
  input  logic [REG_INDEX_BIT_WIDTH-1:0]      ID_dest,
  input  logic                                MEM_valid,
  input  logic [3:0]                          MEM_opcode,
  input  logic                                mem_ready,
  input  logic                                WB_load_valid,
  input  logic [REG_INDEX_BIT_WIDTH-1:0]      WB_index,
  output logic                                stall_if,
  output logic                                stall_id,
  output logic                                bubble_ex,
  output logic                                freeze,
  output logic [2**REG_INDEX_BIT_WIDTH-1:0]   pending_mask,
  output logic [STALL_CNT_WIDTH-1:0]          stall_count,
  output logic                                mem_timeout
);

  import hazard_stall_unit_pkg::*;

  localparam int NUM_REGS = 2 ** REG_INDEX_BIT_WIDTH;
  localparam int WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  logic [NUM_REGS-1:0] clear_vec;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] eff_pending;
  logic                hazard;
  logic                mem_load_stall;
  logic                issue;

  mem_state_t          state;
  mem_state_t          state_next;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [WAIT_W-1:0]   wait_next;
  logic                timeout_next;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    clear_vec = '0;
    set_vec   = '0;
    if (WB_load_valid) clear_vec[WB_index] = 1'b1;
    if (issue)         set_vec[ID_dest]    = 1'b1;
  end

  // Writeback this cycle is visible to the decode read in the same cycle;
  // register 0 is hardwired and can never hold a pending load.
  assign eff_pending = pending_mask & ~clear_vec & ~NUM_REGS'(1);

  assign hazard = ID_valid && (ID_opcode != OP_NOP) &&
                  (eff_pending[ID_src1] || eff_pending[ID_src2]);

  assign mem_load_stall = MEM_valid && (MEM_opcode == OP_LW) && !mem_ready;

  // mem_ready releases the freeze combinationally in the cycle it arrives.
  assign freeze    = mem_load_stall || ((state == MEM_WAIT) && !mem_ready);
  assign stall_if  = hazard || freeze;
  assign stall_id  = hazard || freeze;
  assign bubble_ex = hazard && !freeze;

  assign issue = ID_valid && (ID_opcode == OP_LW) && !hazard && !freeze &&
                 (ID_dest != '0);

  load_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_load_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .set_vec      (set_vec),
    .clear_vec    (clear_vec),
    .pending_mask (pending_mask)
  );

  always_comb begin
    state_next   = state;
    wait_next    = wait_cnt;
    timeout_next = mem_timeout;
    unique case (state)
      RUN: begin
        if (mem_load_stall) begin
          state_next = MEM_WAIT;
          wait_next  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_next = RUN;
          wait_next  = '0;
        end else if (wait_cnt != WAIT_LIMIT) begin
          wait_next = wait_cnt + 1'b1;
        end
      end
      default: begin
        state_next = RUN;
        wait_next  = '0;
      end
    endcase
    // Timing out does not abandon the access; the FSM keeps waiting for mem_ready.
    if ((state_next == MEM_WAIT) && (wait_next == WAIT_LIMIT)) timeout_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_count <= '0;
    end else begin
      state       <= state_next;
      wait_cnt    <= wait_next;
      mem_timeout <= timeout_next;
      if (stall_id && (stall_count != '1)) stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: expected values are queued when the
// stimulus is applied and popped when the matching output is sampled.
module tb_hazard_stall_unit;

  localparam int W = 4;
  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ID_valid;
  logic [3:0]   ID_opcode;
  logic [W-1:0] ID_src1, ID_src2, ID_dest;
  logic         MEM_valid;
  logic [3:0]   MEM_opcode;
  logic         mem_ready;
  logic         WB_load_valid;
  logic [W-1:0] WB_index;
  logic         stall_if, stall_id, bubble_ex, freeze;
  logic [15:0]  pending_mask;
  logic [15:0]  stall_count;
  logic         mem_timeout;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  hazard_stall_unit #(
    .REG_INDEX_BIT_WIDTH (W),
    .STALL_CNT_WIDTH     (16),
    .MAX_WAIT            (255)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ID_valid      (ID_valid),
    .ID_opcode     (ID_opcode),
    .ID_src1       (ID_src1),
    .ID_src2       (ID_src2),
    .ID_dest       (ID_dest),
    .MEM_valid     (MEM_valid),
    .MEM_opcode    (MEM_opcode),
    .mem_ready     (mem_ready),
    .WB_load_valid (WB_load_valid),
    .WB_index      (WB_index),
    .stall_if      (stall_if),
    .stall_id      (stall_id),
    .bubble_ex     (bubble_ex),
    .freeze        (freeze),
    .pending_mask  (pending_mask),
    .stall_count   (stall_count),
    .mem_timeout   (mem_timeout)
  );

  task automatic push(input logic [31:0] e);
    exp_q.push_back(e);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_id(input logic v, input logic [3:0] op,
                          input logic [W-1:0] s1, input logic [W-1:0] s2,
                          input logic [W-1:0] d);
    ID_valid  = v;
    ID_opcode = op;
    ID_src1   = s1;
    ID_src2   = s2;
    ID_dest   = d;
  endtask

  task automatic drive_wb(input logic v, input logic [W-1:0] idx);
    WB_load_valid = v;
    WB_index      = idx;
  endtask

  task automatic drive_mem(input logic v, input logic [3:0] op, input logic rdy);
    MEM_valid  = v;
    MEM_opcode = op;
    mem_ready  = rdy;
  endtask

  initial begin
    rst_n = 1'b0;
    drive_id(1'b0, OP_NOP, '0, '0, '0);
    drive_wb(1'b0, '0);
    drive_mem(1'b0, OP_NOP, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    push(32'h0); push(32'h0); push(32'h0); push(32'h0); push(32'h0); push(32'h0);
    sample();
    check("rst_pending", 32'(pending_mask));
    check("rst_count", 32'(stall_count));
    check("rst_timeout", 32'(mem_timeout));
    check("rst_freeze", 32'(freeze));
    check("rst_stall", 32'(stall_id));
    check("rst_bubble", 32'(bubble_ex));
    tick();

    // LW r5 issues with no hazard
    drive_id(1'b1, OP_LW, 4'd1, 4'd2, 4'd5);
    push(32'h0);
    sample();
    check("lw5_issue_stall", 32'(stall_id));
    tick();

    // Dependent read of r5: one stall with bubble
    drive_id(1'b1, OP_ADD, 4'd5, 4'd0, 4'd6);
    push(32'h0020); push(32'h1); push(32'h1); push(32'h1); push(32'h0);
    sample();
    check("use5_pending", 32'(pending_mask));
    check("use5_stall_id", 32'(stall_id));
    check("use5_stall_if", 32'(stall_if));
    check("use5_bubble", 32'(bubble_ex));
    check("use5_freeze", 32'(freeze));
    tick();

    // Same read coincides with writeback of r5: no hazard
    drive_wb(1'b1, 4'd5);
    push(32'h0020); push(32'h0); push(32'h0); push(32'h1);
    sample();
    check("wb5_pending", 32'(pending_mask));
    check("wb5_stall", 32'(stall_id));
    check("wb5_bubble", 32'(bubble_ex));
    check("wb5_count", 32'(stall_count));
    tick();

    drive_wb(1'b0, '0);
    push(32'h0); push(32'h0);
    sample();
    check("after_wb5_pending", 32'(pending_mask));
    check("after_wb5_stall", 32'(stall_id));
    tick();

    // LW r0 never marks pending
    drive_id(1'b1, OP_LW, 4'd1, 4'd2, 4'd0);
    tick();
    drive_id(1'b1, OP_ADD, 4'd0, 4'd0, 4'd1);
    push(32'h0); push(32'h0);
    sample();
    check("lw0_pending", 32'(pending_mask));
    check("r0_read_stall", 32'(stall_id));
    tick();

    // LW r3, then reissue LW r3 coincident with writeback of r3: set wins
    drive_id(1'b1, OP_LW, 4'd1, 4'd2, 4'd3);
    tick();
    drive_wb(1'b1, 4'd3);
    push(32'h0008);
    sample();
    check("lw3_pending", 32'(pending_mask));
    tick();
    drive_id(1'b0, OP_NOP, '0, '0, '0);
    push(32'h0008);
    sample();
    check("set_wins_r3", 32'(pending_mask));
    tick();
    drive_wb(1'b0, '0);
    push(32'h0);
    sample();
    check("clear_r3", 32'(pending_mask));

    // Mark r7 pending, then a 3-cycle memory wait while decode depends on r7
    drive_id(1'b1, OP_LW, 4'd1, 4'd2, 4'd7);
    tick();
    drive_id(1'b1, OP_ADD, 4'd7, 4'd1, 4'd2);
    drive_mem(1'b1, OP_LW, 1'b0);
    for (int i = 0; i < 3; i++) begin
      push(32'h1); push(32'h0); push(32'h1);
      sample();
      check($sformatf("wait%0d_freeze", i), 32'(freeze));
      check($sformatf("wait%0d_bubble", i), 32'(bubble_ex));
      check($sformatf("wait%0d_stall", i), 32'(stall_id));
      tick();
    end
    drive_id(1'b0, OP_NOP, '0, '0, '0);
    drive_mem(1'b1, OP_LW, 1'b1);
    push(32'h0); push(32'h0);
    sample();
    check("ready_freeze", 32'(freeze));
    check("ready_stall", 32'(stall_id));
    tick();
    drive_mem(1'b0, OP_NOP, 1'b1);
    drive_wb(1'b1, 4'd7);
    push(32'h4);
    sample();
    check("count_after_wait", 32'(stall_count));
    tick();
    drive_wb(1'b0, '0);

    // Memory timeout: 255 cycles with mem_ready low
    drive_mem(1'b1, OP_LW, 1'b0);
    repeat (254) tick();
    push(32'h0);
    sample();
    check("timeout_254", 32'(mem_timeout));
    tick();
    push(32'h1); push(32'h1); push(32'd259);
    sample();
    check("timeout_255", 32'(mem_timeout));
    check("timeout_freeze", 32'(freeze));
    check("timeout_count", 32'(stall_count));
    drive_mem(1'b0, OP_NOP, 1'b0);
    repeat (3) tick();
    push(32'h1); push(32'h1);
    sample();
    check("timeout_sticky", 32'(mem_timeout));
    check("still_mem_wait", 32'(freeze));
    tick();

    // One reset cycle while in MEM_WAIT
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    push(32'h0); push(32'h0); push(32'h0); push(32'h0); push(32'h0); push(32'h0);
    sample();
    check("rst2_timeout", 32'(mem_timeout));
    check("rst2_freeze", 32'(freeze));
    check("rst2_stall", 32'(stall_id));
    check("rst2_bubble", 32'(bubble_ex));
    check("rst2_pending", 32'(pending_mask));
    check("rst2_count", 32'(stall_count));
    tick();

    // Counter saturation: 70000 hazard stall cycles on r9
    drive_mem(1'b0, OP_NOP, 1'b1);
    drive_id(1'b1, OP_LW, 4'd1, 4'd2, 4'd9);
    tick();
    drive_id(1'b1, OP_ADD, 4'd9, 4'd9, 4'd1);
    repeat (65534) tick();
    push(32'hFFFE);
    sample();
    check("count_fffe", 32'(stall_count));
    repeat (70000 - 65534) tick();
    push(32'hFFFF); push(32'h1);
    sample();
    check("count_saturated", 32'(stall_count));
    check("sat_still_stalling", 32'(stall_id));

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL leftover_expectations: observed %0d queued, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
